// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller: mode encoding, default
// timing constants and a small width helper.
package exec_ctrl_pkg;

  localparam logic [1:0] MODE_HALT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;
  localparam logic [1:0] MODE_BP   = 2'd3;

  localparam int DEF_CLK_DIV         = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_ADDR_W          = 4;
  localparam int DEF_CNT_W           = 16;

  // The state encoding is the externally visible mode value.
  typedef enum logic [1:0] {
    ST_HALT = MODE_HALT,
    ST_RUN  = MODE_RUN,
    ST_STEP = MODE_STEP,
    ST_BP   = MODE_BP
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Board/processor side of the execution controller. step_en is a one-cycle
// strobe with no back-pressure: the processor retires one instruction per pulse.
interface exec_ctrl_if #(
  parameter int ADDR_W = exec_ctrl_pkg::DEF_ADDR_W,
  parameter int CNT_W  = exec_ctrl_pkg::DEF_CNT_W
);
  logic              run_btn;
  logic              step_btn;
  logic              halt_btn;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic              step_en;
  logic [1:0]        mode;
  logic              bp_hit;
  logic [CNT_W-1:0]  retired;

  modport master (
    output run_btn, step_btn, halt_btn, bp_en, bp_addr, pc,
    input  step_en, mode, bp_hit, retired
  );

  modport slave (
    input  run_btn, step_btn, halt_btn, bp_en, bp_addr, pc,
    output step_en, mode, bp_hit, retired
  );
endinterface

// File: rtl/exec_ctrl_btn_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stable-count debouncer
// and a one-cycle pulse on each accepted press.
module btn_debounce
  import exec_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive cycles the synchronized level disagrees with
  // the accepted level; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: turns debounced RUN/STEP/HALT buttons and a PC
// breakpoint into a registered one-instruction step_en strobe.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int CLK_DIV         = DEF_CLK_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_ctrl_if.slave  bus
);

  localparam int            DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic w_run_press;
  logic w_step_press;
  logic w_halt_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.run_btn),
    .o_press (w_run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.step_btn),
    .o_press (w_step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.halt_btn),
    .o_press (w_halt_press)
  );

  state_t           r_state;
  logic             r_step_en;
  logic             r_bp_hit;
  logic             r_skip;
  logic [DW-1:0]    r_div;
  logic [CNT_W-1:0] r_retired;

  logic [ADDR_W-1:0] w_pc;
  logic              w_tick;
  logic              w_bp_stop;

  assign w_pc      = bus.pc;
  assign w_tick    = (r_div == DIV_LAST);
  // r_skip lets the instruction we stopped on (or resumed at) execute once.
  assign w_bp_stop = bus.bp_en && (w_pc == bus.bp_addr) && !r_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HALT;
      r_step_en <= 1'b0;
      r_bp_hit  <= 1'b0;
      r_skip    <= 1'b0;
      r_div     <= '0;
      r_retired <= '0;
    end else begin
      r_step_en <= 1'b0;
      case (r_state)
        ST_HALT: begin
          if (!w_halt_press) begin
            if (w_step_press) begin
              r_state   <= ST_STEP;
              r_step_en <= 1'b1;
              r_retired <= r_retired + 1'b1;
            end else if (w_run_press) begin
              r_state <= ST_RUN;
              r_div   <= '0;
              r_skip  <= 1'b1;
            end
          end
        end

        ST_STEP: begin
          r_state <= ST_HALT;
        end

        ST_RUN: begin
          if (w_halt_press) begin
            r_state <= ST_HALT;
            r_div   <= '0;
          end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
              if (w_bp_stop) begin
                r_state  <= ST_BP;
                r_bp_hit <= 1'b1;
              end else begin
                r_step_en <= 1'b1;
                r_retired <= r_retired + 1'b1;
                r_skip    <= 1'b0;
              end
            end
          end
        end

        ST_BP: begin
          if (w_halt_press) begin
            r_state  <= ST_HALT;
            r_bp_hit <= 1'b0;
          end else if (w_step_press) begin
            r_state   <= ST_STEP;
            r_step_en <= 1'b1;
            r_retired <= r_retired + 1'b1;
            r_bp_hit  <= 1'b0;
          end else if (w_run_press) begin
            r_state  <= ST_RUN;
            r_div    <= '0;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.step_en = r_step_en;
  assign bus.mode    = r_state;
  assign bus.bp_hit  = r_bp_hit;
  assign bus.retired = r_retired;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: button presses are scheduled by time, and a mode-level
// model predicts every step_en pulse, which is compared against the DUT.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 16;
  localparam int LAT     = 2 + DEB + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exec_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  exec_ctrl #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cyc_n = 0;

  // ---------------- reference model state ----------------
  logic [1:0]        m_mode = MODE_HALT;
  logic [31:0]       m_run_start = 0;
  bit                m_skip, m_bp, m_en, m_en_prev;
  logic [CNT_W-1:0]  m_ret = '0;
  logic [ADDR_W-1:0] pc_m = '0;

  logic [31:0] sched_run[$], sched_step[$], sched_halt[$];
  logic [31:0] exp_q[$], obs_q[$];

  // One clock: advance, apply presses due at this edge to the model, record
  // pulses, then let the modelled processor advance its pc.
  task automatic cyc();
    bit pr, ps, ph;
    @(posedge clk);
    #1;
    cyc_n = cyc_n + 1;
    pr = 0; ps = 0; ph = 0;
    if (sched_run.size()  > 0 && sched_run[0]  == cyc_n) begin pr = 1; void'(sched_run.pop_front());  end
    if (sched_step.size() > 0 && sched_step[0] == cyc_n) begin ps = 1; void'(sched_step.pop_front()); end
    if (sched_halt.size() > 0 && sched_halt[0] == cyc_n) begin ph = 1; void'(sched_halt.pop_front()); end
    m_en = 0;
    if (!rst_n) begin
      m_mode = MODE_HALT; m_ret = '0; m_bp = 0; m_skip = 0; m_en_prev = 0;
    end else begin
      case (m_mode)
        MODE_HALT: if (!ph) begin
          if (ps) begin m_mode = MODE_STEP; m_en = 1; end
          else if (pr) begin m_mode = MODE_RUN; m_run_start = cyc_n; m_skip = 1; end
        end
        MODE_STEP: m_mode = MODE_HALT;
        MODE_RUN: begin
          if (ph) m_mode = MODE_HALT;
          else if ((cyc_n - m_run_start) % CLK_DIV == 0) begin
            if (bus.bp_en && pc_m == bus.bp_addr && !m_skip) begin
              m_mode = MODE_BP; m_bp = 1;
            end else begin
              m_en = 1; m_skip = 0;
            end
          end
        end
        default: begin
          if (ph) begin m_mode = MODE_HALT; m_bp = 0; end
          else if (ps) begin m_mode = MODE_STEP; m_en = 1; m_bp = 0; end
          else if (pr) begin m_mode = MODE_RUN; m_run_start = cyc_n; m_skip = 1; m_bp = 0; end
        end
      endcase
    end
    if (m_en) begin m_ret = m_ret + 1'b1; exp_q.push_back(cyc_n); end
    if (bus.step_en) obs_q.push_back(cyc_n);
    if (m_en_prev) pc_m = pc_m + 1'b1;
    m_en_prev = m_en;
    bus.pc = pc_m;
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input bit r, input bit s, input bit h, input int hold);
    logic [31:0] at;
    at = cyc_n + LAT;
    bus.run_btn = r; bus.step_btn = s; bus.halt_btn = h;
    if (hold >= DEB) begin
      if (r) sched_run.push_back(at);
      if (s) sched_step.push_back(at);
      if (h) sched_halt.push_back(at);
    end
    repeat (hold) cyc();
    bus.run_btn = 0; bus.step_btn = 0; bus.halt_btn = 0;
    repeat (DEB + 4) cyc();
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.run_btn = 0; bus.step_btn = 0; bus.halt_btn = 0;
    bus.bp_en = 0; bus.bp_addr = '0;
    pc_m = '0; bus.pc = '0;
    sched_run.delete(); sched_step.delete(); sched_halt.delete();
    repeat (3) cyc();
    rst_n = 1;
    repeat (2) cyc();
    exp_q.delete(); obs_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL reset_mode: got %0d want %0d", bus.mode, MODE_HALT); end
    n_cmp++; if (bus.step_en !== 1'b0) begin n_bad++; $display("FAIL reset_step_en: got %b want 0", bus.step_en); end
    n_cmp++; if (bus.retired !== '0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
    n_cmp++; if (bus.bp_hit !== 1'b0) begin n_bad++; $display("FAIL reset_bp_hit: got %b want 0", bus.bp_hit); end
    repeat (100) cyc();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL idle_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (bus.mode !== m_mode) begin n_bad++; $display("FAIL idle_mode: got %0d want %0d", bus.mode, m_mode); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL idle_retired: got %0d want %0d", bus.retired, m_ret); end
  endtask

  task automatic test_step();
    logic [31:0] raise;
    exp_q.delete(); obs_q.delete();
    raise = cyc_n;
    press(0, 1, 0, 10);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL step_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL step_cycle[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (obs_q.size() < 1 || obs_q[0] !== raise + LAT) begin n_bad++; $display("FAIL step_latency: got %0d want %0d", (obs_q.size() > 0) ? obs_q[0] - raise : 0, LAT); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL step_retired: got %0d want %0d", bus.retired, m_ret); end
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL step_mode: got %0d want %0d", bus.mode, MODE_HALT); end
    exp_q.delete(); obs_q.delete();
    press(0, 1, 0, $urandom_range(1, DEB - 1));
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL glitch_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL glitch_retired: got %0d want %0d", bus.retired, m_ret); end
  endtask

  task automatic test_run();
    logic [31:0] halt_edge;
    bit seen;
    do_reset();
    pc_m = ADDR_W'($urandom_range(0, 15)); bus.pc = pc_m;
    press(1, 0, 0, DEB + $urandom_range(0, 4));
    for (int k = 0; k < 200 && obs_q.size() < 20; k++) cyc();
    n_cmp++; if (obs_q.size() < 20) begin n_bad++; $display("FAIL run_timeout: got %0d pulses want 20", obs_q.size()); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL run_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL run_cycle[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] - obs_q[i-1] !== CLK_DIV) begin n_bad++; $display("FAIL run_spacing[%0d]: got %0d want %0d", i, obs_q[i] - obs_q[i-1], CLK_DIV); end
    end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL run_retired: got %0d want %0d", bus.retired, m_ret); end
    // align the halt press so it is consumed on a tick edge
    for (int k = 0; k < CLK_DIV && ((cyc_n + LAT - m_run_start) % CLK_DIV) != 0; k++) cyc();
    halt_edge = cyc_n + LAT;
    press(0, 0, 1, DEB + 1);
    seen = 0;
    foreach (obs_q[i]) if (obs_q[i] == halt_edge) seen = 1;
    n_cmp++; if (seen) begin n_bad++; $display("FAIL halt_on_tick: got pulse at %0d want none", halt_edge); end
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL halt_mode: got %0d want %0d", bus.mode, MODE_HALT); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL halt_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL halt_retired: got %0d want %0d", bus.retired, m_ret); end
  endtask

  task automatic test_breakpoint();
    logic [ADDR_W-1:0] addr;
    do_reset();
    bus.bp_en = 1; bus.bp_addr = 4'd5;
    press(1, 0, 0, DEB + 1);
    for (int k = 0; k < 100 && bus.mode !== MODE_BP; k++) cyc();
    cyc();
    n_cmp++; if (bus.mode !== m_mode || m_mode !== MODE_BP) begin n_bad++; $display("FAIL bp_mode: got %0d want %0d", bus.mode, m_mode); end
    n_cmp++; if (bus.bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_hit: got %b want 1", bus.bp_hit); end
    n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL bp_pulses: got %0d want 5", obs_q.size()); end
    n_cmp++; if (pc_m !== 4'd5) begin n_bad++; $display("FAIL bp_pc: got %0d want 5", pc_m); end
    exp_q.delete(); obs_q.delete();
    press(1, 0, 0, DEB);
    for (int k = 0; k < 16 * CLK_DIV + 40 && bus.mode !== MODE_BP; k++) cyc();
    cyc();
    n_cmp++; if (obs_q.size() != 16) begin n_bad++; $display("FAIL bp_wrap_pulses: got %0d want 16", obs_q.size()); end
    n_cmp++; if (bus.mode !== MODE_BP || bus.bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_wrap_stop: got mode %0d hit %b want 3/1", bus.mode, bus.bp_hit); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_wrap_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_wrap_cycle[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
    press(0, 1, 0, DEB);
    n_cmp++; if (obs_q.size() != 1 || exp_q.size() != 1) begin n_bad++; $display("FAIL bp_step_off: got %0d pulses want 1", obs_q.size()); end
    n_cmp++; if (bus.mode !== MODE_HALT || bus.bp_hit !== 1'b0) begin n_bad++; $display("FAIL bp_step_state: got mode %0d hit %b want 0/0", bus.mode, bus.bp_hit); end
    n_cmp++; if (pc_m !== 4'd6) begin n_bad++; $display("FAIL bp_step_pc: got %0d want 6", pc_m); end
    // random breakpoint address and start pc, then leave BP with halt
    addr = ADDR_W'($urandom_range(0, 15));
    bus.bp_addr = addr;
    pc_m = ADDR_W'($urandom_range(0, 15)); bus.pc = pc_m;
    exp_q.delete(); obs_q.delete();
    press(1, 0, 0, DEB + 2);
    for (int k = 0; k < 16 * CLK_DIV + 60 && bus.mode !== MODE_BP; k++) cyc();
    cyc();
    n_cmp++; if (pc_m !== addr || bus.mode !== MODE_BP) begin n_bad++; $display("FAIL bp_rand_stop: got pc %0d mode %0d want pc %0d mode 3", pc_m, bus.mode, addr); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_rand_cycle[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    press(0, 0, 1, DEB);
    n_cmp++; if (bus.mode !== MODE_HALT || bus.bp_hit !== 1'b0) begin n_bad++; $display("FAIL bp_halt: got mode %0d hit %b want 0/0", bus.mode, bus.bp_hit); end
    bus.bp_en = 0;
  endtask

  task automatic test_simultaneous();
    exp_q.delete(); obs_q.delete();
    press(1, 0, 1, DEB + 1);
    repeat (12) cyc();
    n_cmp++; if (obs_q.size() != 0 || exp_q.size() != 0) begin n_bad++; $display("FAIL run_halt_pulses: got %0d want 0", obs_q.size()); end
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL run_halt_mode: got %0d want 0", bus.mode); end
    press(1, 1, 0, DEB + 1);
    repeat (12) cyc();
    n_cmp++; if (obs_q.size() != 1 || exp_q.size() != 1) begin n_bad++; $display("FAIL step_run_pulses: got %0d want 1", obs_q.size()); end
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL step_run_mode: got %0d want 0", bus.mode); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL step_run_retired: got %0d want %0d", bus.retired, m_ret); end
  endtask

  task automatic test_random();
    int combo;
    exp_q.delete(); obs_q.delete();
    for (int it = 0; it < 12; it++) begin
      combo = $urandom_range(1, 7);
      bus.bp_en = 1'($urandom_range(0, 1));
      bus.bp_addr = ADDR_W'($urandom_range(0, 15));
      press(combo[0], combo[1], combo[2], $urandom_range(1, DEB + 3));
      repeat ($urandom_range(0, 24)) cyc();
    end
    press(0, 0, 1, DEB);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_cycle[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (bus.mode !== m_mode) begin n_bad++; $display("FAIL rand_mode: got %0d want %0d", bus.mode, m_mode); end
    n_cmp++; if (bus.bp_hit !== m_bp) begin n_bad++; $display("FAIL rand_bp_hit: got %b want %b", bus.bp_hit, m_bp); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL rand_retired: got %0d want %0d", bus.retired, m_ret); end
    bus.bp_en = 0;
  endtask

  task automatic test_reset_on_tick();
    int k;
    do_reset();
    press(1, 0, 0, DEB + 1);
    for (k = 0; k < 20 && bus.step_en !== 1'b1; k++) cyc();
    n_cmp++; if (bus.step_en !== 1'b1) begin n_bad++; $display("FAIL rst_tick_wait: got step_en %b want 1", bus.step_en); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (bus.step_en !== 1'b0) begin n_bad++; $display("FAIL rst_tick_step_en: got %b want 0", bus.step_en); end
    n_cmp++; if (bus.retired !== '0) begin n_bad++; $display("FAIL rst_tick_retired: got %0d want 0", bus.retired); end
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL rst_tick_mode: got %0d want 0", bus.mode); end
    repeat (2) cyc();
    rst_n = 1;
    exp_q.delete(); obs_q.delete();
    repeat (30) cyc();
    n_cmp++; if (obs_q.size() != 0 || exp_q.size() != 0) begin n_bad++; $display("FAIL post_rst_pulses: got %0d want 0", obs_q.size()); end
    n_cmp++; if (bus.mode !== m_mode) begin n_bad++; $display("FAIL post_rst_mode: got %0d want %0d", bus.mode, m_mode); end
    n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL post_rst_retired: got %0d want %0d", bus.retired, m_ret); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.run_btn = 0; bus.step_btn = 0; bus.halt_btn = 0;
    bus.bp_en = 0; bus.bp_addr = '0; bus.pc = '0;
    test_reset();
    test_step();
    test_run();
    test_breakpoint();
    test_simultaneous();
    test_random();
    test_reset_on_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Execution controller for the 16-bit, 16-entry-ROM processor core.
- Replaces the free-running timer-modulo stepping with an explicit sequencer: a one-cycle `step_en` strobe lets the processor fetch, decode and retire exactly one instruction.
- Supports three modes, driven by board push-buttons: RUN (divided free-running tick), single STEP and HALT.
- Supports a PC breakpoint. Sits between the board buttons and the processor's clock-enable input.

Parameters:
- CLK_DIV, 50000000: clock cycles per `step_en` pulse in RUN; legal range is 1 or more.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized cycles before a button level is accepted; 1 or more.
- ADDR_W, 4: PC / breakpoint address width.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run_btn  in  1  raw asynchronous button, request RUN
- step_btn  in  1  raw asynchronous button, request single step
- halt_btn  in  1  raw asynchronous button, request HALT
- bp_en  in  1  breakpoint enable (quasi-static)
- bp_addr  in  ADDR_W  breakpoint address
- pc  in  ADDR_W  processor's current instruction address
- step_en  out  1  one-cycle strobe; processor executes one instruction
- mode  out  2  0=HALT, 1=RUN, 2=STEP, 3=BP_HIT
- bp_hit  out  1  high while stopped on breakpoint
- retired  out  CNT_W  count of `step_en` pulses issued

Behaviour:
- Reset (async, rst_n=0):
  - mode=HALT, step_en=0, bp_hit=0, retired=0.
  - Divider, debouncers and resume_skip are cleared.
  - Takes effect immediately, including mid-pulse.
- Button path, per button:
  - 2-flop synchronizer, then debouncer.
  - The debounced level changes only after the synchronized level has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - A debounced 0->1 edge gives a one-cycle press pulse.
  - Press latency from the raw edge is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- Simultaneous presses: halt > step > run; lower-priority presses in that cycle are dropped.
- HALT:
  - step press -> STEP.
  - run press -> RUN, with divider=0 and resume_skip=1.
- STEP:
  - step_en=1 for exactly this one cycle.
  - Next state is always HALT, even if another press arrives.
  - Breakpoint is not checked, so the user can step off a breakpoint.
- RUN:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - "Tick" is the cycle with divider==CLK_DIV-1. With CLK_DIV=1 every cycle is a tick.
  - On a tick with bp_en=1, pc==bp_addr and resume_skip=0: no pulse; go to BP_HIT; bp_hit=1.
  - On any other tick: step_en=1 and resume_skip clears.
  - halt press -> HALT with divider cleared. Halt wins over a tick in the same cycle, so no pulse.
  - step press in RUN is ignored.
- BP_HIT:
  - step press -> STEP, with bp_hit cleared.
  - run press -> RUN, with resume_skip=1 so the breakpointed instruction executes once.
  - halt press -> HALT, with bp_hit cleared.
- Counter and outputs:
  - retired increments on every step_en pulse and wraps modulo 2^CNT_W.
  - step_en, mode and bp_hit are registered outputs; no combinational paths from inputs.
  - step_en is never high for two consecutive cycles unless CLK_DIV=1 in RUN.

Decomposition:
- Shared package holds:
  - mode encoding constants: MODE_HALT=0, MODE_RUN=1, MODE_STEP=2, MODE_BP=3.
  - default CLK_DIV and DEBOUNCE_CYCLES values, so board top and benches agree.
- One sub-module, btn_debounce, instantiated three times. It contains the synchronizer, the stable-count debouncer and the rising-edge press pulse, parameterised by DEBOUNCE_CYCLES.

Test Plan (CLK_DIV=4, DEBOUNCE_CYCLES=3, ADDR_W=4):
1. Reset, then hold: mode=0, step_en=0 and retired=0 for 100 cycles.
2. step_btn high for 10 cycles: exactly one step_en pulse, 6 cycles after the raw edge; retired=1; mode returns to 0. A 2-cycle step_btn glitch produces no pulse.
3. run press, pc driven 0..15: step_en every 4th cycle; after 20 pulses retired=20. halt press on a tick cycle gives no pulse on that cycle and mode=0.
4. bp_en=1, bp_addr=5, run from pc=0: pulses at pc=0..4, then mode=3 and bp_hit=1 with no pulse at pc=5. A run press gives one pulse at pc=5, then continues. If pc wraps back to 5, it stops again.
5. run_btn and halt_btn pressed in the same cycle from HALT: halt wins, mode stays 0 and no pulses. step+run together from HALT: single step only.
6. rst_n driven low in the same cycle as a RUN tick: step_en low immediately, retired=0. After release, mode=0 and no pulses until a press.
